// File: rtl/ttl_pkg.sv
`timescale 1ns/1ps
// Shared constants for the clocked 3-state TTL family models.
package ttl_pkg;

  localparam int TTL_DELAY_RISE_DEFAULT = 5;
  localparam int TTL_DELAY_FALL_DEFAULT = 3;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int ttl_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ttl_573_fifo_if.sv
`timescale 1ns/1ps
// Producer/consumer side of the '573 FIFO: write/pop strobes, output enable and status.
interface ttl_573_fifo_if
  import ttl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = ttl_count_width(DEPTH)
);

  logic [WIDTH-1:0] D;
  logic             WE;
  logic             RE;
  logic             OE_bar;
  logic             Empty;
  logic             Full;
  logic [CW-1:0]    Count;

  modport master (
    output D, WE, RE, OE_bar,
    input  Empty, Full, Count
  );

  modport slave (
    input  D, WE, RE, OE_bar,
    output Empty, Full, Count
  );

endinterface

// File: rtl/ttl_573_fifo_ptr.sv
`timescale 1ns/1ps
// Modulo-DEPTH wrap counter used for the FIFO read and write pointers.
module ttl_fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap so non-power-of-two depths skip the unused codes.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      if (ptr_q == PW'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ttl_573_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through FIFO with '573-style latch hold of the last popped word
// and a delayed 3-state output bus.
module ttl_573_fifo
  import ttl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int DELAY_RISE = TTL_DELAY_RISE_DEFAULT,
  parameter int DELAY_FALL = TTL_DELAY_FALL_DEFAULT,
  localparam int CW        = ttl_count_width(DEPTH),
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  ttl_573_fifo_if.slave     bus,
  output wire [WIDTH-1:0]   Y
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q,  full_d;
  logic [WIDTH-1:0] held_q,  held_d;
  logic             push_ok;
  logic             pop_ok;

  // A full buffer still accepts a write when a pop frees the slot on the same edge.
  assign pop_ok  = bus.RE && !empty_q;
  assign push_ok = bus.WE && (!full_q || pop_ok);

  ttl_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .Clk   (Clk),
    .Reset (Reset),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  ttl_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .Clk   (Clk),
    .Reset (Reset),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    held_d  = held_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (pop_ok) begin
      held_d = mem[rd_ptr];
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      held_q  <= '0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      held_q  <= held_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge Clk) begin
    if (push_ok && !Reset) begin
      mem[wr_ptr] <= bus.D;
    end
  end

  assign bus.Count = count_q;
  assign bus.Empty = empty_q;
  assign bus.Full  = full_q;

  logic [WIDTH-1:0] y_src;
  logic [WIDTH-1:0] y_rise, y_fall, y_val;
  logic             oe_rise, oe_fall;
  logic [WIDTH-1:0] y_drv;

  assign y_src = empty_q ? held_q : mem[rd_ptr];

  // Separate rise/fall paths: a bit goes low after the fall delay, high only
  // once the rise-delayed copy has also gone high.
  assign #(DELAY_RISE) y_rise  = y_src;
  assign #(DELAY_FALL) y_fall  = y_src;
  assign #(DELAY_RISE) oe_rise = !bus.OE_bar;
  assign #(DELAY_FALL) oe_fall = !bus.OE_bar;

  assign y_val = y_rise & y_fall;
  assign y_drv = {WIDTH{oe_fall}} & ({WIDTH{oe_rise}} | ~y_val);

  for (genvar i = 0; i < WIDTH; i++) begin : g_y
    assign Y[i] = y_drv[i] ? y_val[i] : 1'bz;
  end

endmodule
